// File: rtl/alu_issue.sv
// Decode-and-issue front end for the integer ALU: decodes one RV32I
// ALU instruction, holds the ALU inputs, and returns the writeback result.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic [3:0]  aluop,
    output logic [31:0] aluin1,
    output logic [31:0] aluin2,
    input  logic [31:0] aluout,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_illegal
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_SLT,
        CLS_SLTU
    } cls_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SLL = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SRL = 4'd4;
    localparam logic [3:0] OP_SRA = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;

    state_t      state;
    cls_t        cls_q;
    logic [4:0]  rd_q;
    logic        ill_q;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] rs2_sh;
    logic [31:0] imm_sh;

    logic [3:0]  d_op;
    logic [31:0] d_a;
    logic [31:0] d_b;
    cls_t        d_cls;
    logic        d_ill;
    logic [4:0]  d_rd;

    logic        accept;
    logic        slt_bit;
    logic        sltu_bit;
    logic        sign_diff;
    logic        unused_rs1_field;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign rs2_sh = {27'b0, in_rs2_data[4:0]};
    assign imm_sh = {27'b0, in_instr[24:20]};

    // Operands arrive as data, so the rs1 register index is not needed.
    assign unused_rs1_field = ^in_instr[19:15];

    always_comb begin
        d_op  = OP_ADD;
        d_a   = 32'b0;
        d_b   = 32'b0;
        d_cls = CLS_ALU;
        d_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                d_a = in_rs1_data;
                d_b = in_rs2_data;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: d_op = OP_ADD;
                        3'd1: begin
                            d_op = OP_SLL;
                            d_b  = rs2_sh;
                        end
                        3'd2: begin
                            d_op  = OP_SUB;
                            d_cls = CLS_SLT;
                        end
                        3'd3: begin
                            d_op  = OP_SUB;
                            d_cls = CLS_SLTU;
                        end
                        3'd4: d_op = OP_XOR;
                        3'd5: begin
                            d_op = OP_SRL;
                            d_b  = rs2_sh;
                        end
                        3'd6: d_op = OP_OR;
                        default: d_op = OP_AND;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    d_op = OP_SUB;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    d_op = OP_SRA;
                    d_b  = rs2_sh;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OPC_IMM: begin
                d_a = in_rs1_data;
                d_b = imm_i;
                case (f3)
                    3'd0: d_op = OP_ADD;
                    3'd1: begin
                        d_op  = OP_SLL;
                        d_b   = imm_sh;
                        d_ill = (f7 != 7'h00);
                    end
                    3'd2: begin
                        d_op  = OP_SUB;
                        d_cls = CLS_SLT;
                    end
                    3'd3: begin
                        d_op  = OP_SUB;
                        d_cls = CLS_SLTU;
                    end
                    3'd4: d_op = OP_XOR;
                    3'd5: begin
                        d_b = imm_sh;
                        if (f7 == 7'h00) begin
                            d_op = OP_SRL;
                        end else if (f7 == 7'h20) begin
                            d_op = OP_SRA;
                        end else begin
                            d_ill = 1'b1;
                        end
                    end
                    3'd6: d_op = OP_OR;
                    default: d_op = OP_AND;
                endcase
            end
            OPC_LUI: begin
                d_a = 32'b0;
                d_b = imm_u;
            end
            OPC_AUIPC: begin
                d_a = in_pc;
                d_b = imm_u;
            end
            default: d_ill = 1'b1;
        endcase
        // Illegal instructions present an all-zero add to the ALU.
        if (d_ill) begin
            d_op  = OP_ADD;
            d_a   = 32'b0;
            d_b   = 32'b0;
            d_cls = CLS_ALU;
        end
    end

    assign d_rd = d_ill ? 5'd0 : in_instr[11:7];

    assign in_ready = (state == IDLE) ||
                      (state == RESP && wb_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            aluop  <= OP_ADD;
            aluin1 <= 32'b0;
            aluin2 <= 32'b0;
            rd_q   <= 5'd0;
            cls_q  <= CLS_ALU;
            ill_q  <= 1'b0;
        end else begin
            if (accept) begin
                aluop  <= d_op;
                aluin1 <= d_a;
                aluin2 <= d_b;
                rd_q   <= d_rd;
                cls_q  <= d_cls;
                ill_q  <= d_ill;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    state <= RESP;
                end
                RESP: begin
                    if (wb_ready) begin
                        state <= in_valid ? EXEC : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Differing signs decide the compare outright; otherwise a-b cannot
    // overflow and its sign bit is the answer.
    assign sign_diff = aluin1[31] ^ aluin2[31];
    assign slt_bit   = sign_diff ? aluin1[31] : aluout[31];
    assign sltu_bit  = sign_diff ? aluin2[31] : aluout[31];

    assign wb_valid   = (state == RESP);
    assign wb_illegal = wb_valid && ill_q;
    assign wb_rd      = wb_valid ? rd_q : 5'd0;

    always_comb begin
        wb_data = 32'b0;
        if (wb_valid && !ill_q && rd_q != 5'd0) begin
            case (cls_q)
                CLS_SLT:  wb_data = {31'b0, slt_bit};
                CLS_SLTU: wb_data = {31'b0, sltu_bit};
                default:  wb_data = aluout;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed table, corner sequences,
// and random instructions against an instruction-level reference model.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [3:0]  aluop;
    logic [31:0] aluin1;
    logic [31:0] aluin2;
    logic [31:0] aluout;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_illegal;

    int errors = 0;
    int checks = 0;

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .aluop       (aluop),
        .aluin1      (aluin1),
        .aluin2      (aluin2),
        .aluout      (aluout),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_illegal  (wb_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        case (op)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x << y[4:0];
            4'd3: return x ^ y;
            4'd4: return x >> y[4:0];
            4'd5: return $signed(x) >>> y[4:0];
            4'd6: return x | y;
            4'd7: return x & y;
            default: return 32'b0;
        endcase
    endfunction

    // External ALU: result registered one edge after its inputs.
    initial aluout = 32'b0;
    always @(posedge clk) aluout <= alu_f(aluop, aluin1, aluin2);

    function automatic logic [31:0] enc_r(input logic [6:0] f7,
                                          input logic [4:0] rs2,
                                          input logic [4:0] rs1,
                                          input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm,
                                          input logic [4:0] rs1,
                                          input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm,
                                          input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    // Architectural result of the instruction, straight from the ISA rules.
    task automatic ref_model(input logic [31:0] ins,
                             input logic [31:0] pc,
                             input logic [31:0] a,
                             input logic [31:0] b,
                             output logic [31:0] data,
                             output logic [4:0] rd,
                             output logic ill);
        logic [31:0] r;
        logic [31:0] imm;
        logic [6:0]  f7;
        logic [2:0]  f3;
        r   = 32'b0;
        ill = 1'b0;
        f7  = ins[31:25];
        f3  = ins[14:12];
        imm = {{20{ins[31]}}, ins[31:20]};
        case (ins[6:0])
            7'b0110011: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: r = a + b;
                        3'd1: r = a << b[4:0];
                        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd3: r = (a < b) ? 32'd1 : 32'd0;
                        3'd4: r = a ^ b;
                        3'd5: r = a >> b[4:0];
                        3'd6: r = a | b;
                        default: r = a & b;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    r = a - b;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    r = $signed(a) >>> b[4:0];
                end else begin
                    ill = 1'b1;
                end
            end
            7'b0010011: begin
                case (f3)
                    3'd0: r = a + imm;
                    3'd1: begin
                        if (f7 == 7'h00) r = a << ins[24:20];
                        else ill = 1'b1;
                    end
                    3'd2: r = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                    3'd3: r = (a < imm) ? 32'd1 : 32'd0;
                    3'd4: r = a ^ imm;
                    3'd5: begin
                        if (f7 == 7'h00) r = a >> ins[24:20];
                        else if (f7 == 7'h20) r = $signed(a) >>> ins[24:20];
                        else ill = 1'b1;
                    end
                    3'd6: r = a | imm;
                    default: r = a & imm;
                endcase
            end
            7'b0110111: r = {ins[31:12], 12'b0};
            7'b0010111: r = pc + {ins[31:12], 12'b0};
            default: ill = 1'b1;
        endcase
        rd   = ill ? 5'd0 : ins[11:7];
        data = (ill || rd == 5'd0) ? 32'b0 : r;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full transaction from IDLE; stall = RESP cycles with wb_ready low.
    task automatic run_one(input logic [31:0] ins,
                           input logic [31:0] pc,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input int stall,
                           output logic [3:0] op,
                           output logic [31:0] in1,
                           output logic [31:0] in2,
                           output logic [4:0] rd,
                           output logic [31:0] data,
                           output logic ill);
        in_instr    = ins;
        in_pc       = pc;
        in_rs1_data = a;
        in_rs2_data = b;
        in_valid    = 1'b1;
        wb_ready    = 1'b1;
        #1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = $urandom;
        chk("exec_wb_valid", 32'(wb_valid), 32'd0);
        chk("exec_in_ready", 32'(in_ready), 32'd0);
        op       = aluop;
        in1      = aluin1;
        in2      = aluin2;
        wb_ready = (stall == 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < stall; i++) begin
            chk("stall_wb_valid", 32'(wb_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_aluin2", aluin2, in2);
            @(posedge clk);
            #1;
        end
        wb_ready = 1'b1;
        #1;
        chk("resp_wb_valid", 32'(wb_valid), 32'd1);
        rd   = wb_rd;
        data = wb_data;
        ill  = wb_illegal;
        @(posedge clk);
        #1;
        chk("after_wb_valid", 32'(wb_valid), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [3:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_ill;
        logic [31:0] ins;
        logic [31:0] h1;
        logic [31:0] h2;

        vecs.push_back('{"addi", 32'hFFF08293, 0, 5, 0,
                         0, 5, 32'hFFFFFFFF, 5, 4, 0});
        vecs.push_back('{"slt", enc_r(7'h00, 2, 1, 3'd2, 3), 0,
                         32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 1, 3, 1, 0});
        vecs.push_back('{"sltu", enc_r(7'h00, 2, 1, 3'd3, 4), 0,
                         32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 1, 4, 0, 0});
        vecs.push_back('{"sub", enc_r(7'h20, 2, 1, 3'd0, 6), 0,
                         3, 5, 1, 3, 5, 6, 32'hFFFFFFFE, 0});
        vecs.push_back('{"sra", enc_r(7'h20, 2, 1, 3'd5, 8), 0,
                         32'h80000000, 32'h23, 5, 32'h80000000, 3, 8,
                         32'hF0000000, 0});
        vecs.push_back('{"srli", enc_i({7'h00, 5'd31}, 1, 3'd5, 9), 0,
                         32'h80000000, 0, 4, 32'h80000000, 31, 9, 1, 0});
        vecs.push_back('{"srai", enc_i({7'h20, 5'd4}, 1, 3'd5, 12), 0,
                         32'h80000000, 0, 5, 32'h80000000, 4, 12,
                         32'hF8000000, 0});
        vecs.push_back('{"lui", enc_u(20'h12345, 7, 7'b0110111), 0,
                         32'hDEAD, 0, 0, 0, 32'h12345000, 7,
                         32'h12345000, 0});
        vecs.push_back('{"auipc", enc_u(20'h00001, 10, 7'b0010111),
                         32'h100, 0, 0, 0, 32'h100, 32'h1000, 10,
                         32'h1100, 0});
        vecs.push_back('{"mul", enc_r(7'h01, 2, 1, 3'd0, 11), 0,
                         7, 9, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{"slli_bad", enc_i({7'h20, 5'd3}, 1, 3'd1, 13), 0,
                         7, 0, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{"add_x0", enc_r(7'h00, 2, 1, 3'd0, 0), 0,
                         1, 2, 0, 1, 2, 0, 0, 0});
        vecs.push_back('{"sll_mask", enc_r(7'h00, 2, 1, 3'd1, 14), 0,
                         1, 32'hFFFFFFE4, 2, 1, 4, 14, 16, 0});

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        wb_ready    = 1'b1;
        in_instr    = 32'b0;
        in_pc       = 32'b0;
        in_rs1_data = 32'b0;
        in_rs2_data = 32'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_aluop", 32'(aluop), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_one(vecs[i].ins, vecs[i].pc, vecs[i].a, vecs[i].b, 0,
                    op, in1, in2, rd, data, ill);
            chk({vecs[i].name, "_aluop"}, 32'(op), 32'(vecs[i].op));
            chk({vecs[i].name, "_aluin1"}, in1, vecs[i].in1);
            chk({vecs[i].name, "_aluin2"}, in2, vecs[i].in2);
            chk({vecs[i].name, "_wb_rd"}, 32'(rd), 32'(vecs[i].rd));
            chk({vecs[i].name, "_wb_data"}, data, vecs[i].data);
            chk({vecs[i].name, "_illegal"}, 32'(ill), 32'(vecs[i].ill));
        end

        // Backpressure for 3 cycles, then accept on the wb_ready edge.
        in_instr    = enc_r(7'h00, 2, 1, 3'd0, 5);
        in_rs1_data = 1;
        in_rs2_data = 2;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wb_ready = 1'b0;
        @(posedge clk);
        #1;
        h1 = aluin1;
        h2 = aluin2;
        for (int i = 0; i < 3; i++) begin
            chk("bp_wb_valid", 32'(wb_valid), 32'd1);
            chk("bp_wb_data", wb_data, 32'd3);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_aluin1", aluin1, 32'd1);
            chk("bp_aluin2", aluin2, 32'd2);
            @(posedge clk);
            #1;
        end
        in_instr    = enc_i(12'd7, 1, 3'd0, 6);
        in_rs1_data = 10;
        in_valid    = 1'b1;
        wb_ready    = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        chk("b2b_old_data", wb_data, 32'd3);
        chk("b2b_old_in1", h1 ^ aluin1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_exec_valid", 32'(wb_valid), 32'd0);
        chk("b2b_exec_in1", aluin1, 32'd10);
        @(posedge clk);
        #1;
        chk("b2b_wb_valid", 32'(wb_valid), 32'd1);
        chk("b2b_wb_rd", 32'(wb_rd), 32'd6);
        chk("b2b_wb_data", wb_data, 32'd17);
        @(posedge clk);
        #1;
        chk("b2b_idle", 32'(wb_valid), 32'd0);
        chk("b2b_h2_old", h2, 32'd2);

        // Reset pulsed while the instruction sits in EXEC.
        in_instr    = enc_r(7'h20, 2, 1, 3'd0, 6);
        in_rs1_data = 3;
        in_rs2_data = 5;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("rx_exec_aluop", 32'(aluop), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rx_aluop", 32'(aluop), 32'd0);
        chk("rx_aluin1", aluin1, 32'd0);
        chk("rx_aluin2", aluin2, 32'd0);
        chk("rx_in_ready", 32'(in_ready), 32'd1);
        chk("rx_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rx_no_wb", 32'(wb_valid), 32'd0);
            chk("rx_ready", 32'(in_ready), 32'd1);
        end

        // Random instructions against the reference model.
        for (int n = 0; n < 300; n++) begin
            int kind;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] pc;
            logic [6:0]  f7;
            kind = $urandom_range(0, 5);
            a    = $urandom;
            b    = $urandom;
            pc   = $urandom;
            if ($urandom_range(0, 3) == 0) a = {a[31], 31'b0};
            if ($urandom_range(0, 3) == 0) b = a ^ 32'h80000000;
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            ins = $urandom;
            case (kind)
                0, 1: ins = enc_r(f7, ins[24:20], ins[19:15],
                                  ins[14:12], ins[11:7]);
                2:    ins = enc_i({f7, ins[24:20]}, ins[19:15],
                                  ins[14:12], ins[11:7]);
                3:    ins = enc_i(ins[31:20], ins[19:15],
                                  ins[14:12], ins[11:7]);
                4:    ins = enc_u(ins[31:12], ins[11:7],
                                  ins[5] ? 7'b0110111 : 7'b0010111);
                default: ;
            endcase
            ref_model(ins, pc, a, b, e_data, e_rd, e_ill);
            run_one(ins, pc, a, b, $urandom_range(0, 2),
                    op, in1, in2, rd, data, ill);
            chk("rnd_wb_data", data, e_data);
            chk("rnd_wb_rd", 32'(rd), 32'(e_rd));
            chk("rnd_illegal", 32'(ill), 32'(e_ill));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
